// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   FETCH_XLEN    - PC width carried inside a fetch entry
//   HALT_WORD     - instruction word that stops fetching
//   imem_aw()     - word-address width for a given memory depth
//   fetch_entry_t - one buffered instruction {instr, pc}
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int FETCH_XLEN = 64;

   localparam logic [31:0] HALT_WORD = 32'h0000_0000;

   // A depth of 1 still needs a one-bit address port.
   function automatic int imem_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef struct packed {
      logic [31:0]           instr;
      logic [FETCH_XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO of fetched instructions sitting between the instruction
// memory and the decode stage.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush            drop every entry (redirect); wins over enq/deq
//   enq, enq_data    push one entry
//   deq              pop the head entry
//   head             oldest entry (meaningful only when !empty)
//   count            number of entries held (0..2)
//   full, empty      occupancy flags
// -----------------------------------------------------------------------------
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         enq,
   input  fetch_entry_t enq_data,
   input  logic         deq,
   output fetch_entry_t head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t slot [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt_q;
   logic         do_enq;
   logic         do_deq;

   assign full   = (cnt_q == 2'd2);
   assign empty  = (cnt_q == 2'd0);
   assign count  = cnt_q;
   assign head   = slot[rd_ptr];

   // A full buffer may still accept a push when the head leaves this cycle.
   assign do_enq = enq && !flush && (!full || deq);
   assign do_deq = deq && !empty && !flush;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its neighbours, independent of order.
      if (!rst_n || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (do_enq) wr_ptr <= ~wr_ptr;
         if (do_deq) rd_ptr <= ~rd_ptr;
         cnt_q <= cnt_q + 2'(do_enq) - 2'(do_deq);
      end
   end

   // NOTE: entry storage is deliberately not reset; the count says which slots
   // hold live data, so clearing the payload would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_enq) slot[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC and a synchronous-read instruction memory with a
// program-load write port, and hands one instruction per cycle to decode over
// a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   run                        allow new memory reads
//   imem_we/waddr/wdata        instruction memory write port
//   redirect_valid/pc          restart fetching at a new byte address
//   if_valid/if_ready          output handshake
//   if_instr/if_pc             instruction word and its byte address
//   halted                     sticky, all-zero word fetched (redirect clears)
//   fault                      sticky, misaligned or out-of-range PC
// The word returning from memory is presented directly when the buffer is
// empty, so an instruction issued in one cycle is visible in the next.
// Read slot plus buffered entries never exceed two, so nothing is lost under
// backpressure.
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN       = FETCH_XLEN,
   parameter int              IMEM_DEPTH = 256,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           run,
   input  logic                           imem_we,
   input  logic [imem_aw(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                    imem_wdata,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   output logic                           if_valid,
   input  logic                           if_ready,
   output logic [31:0]                    if_instr,
   output logic [XLEN-1:0]                if_pc,
   output logic                           halted,
   output logic                           fault
);

   localparam int              AW          = imem_aw(IMEM_DEPTH);
   localparam logic [XLEN-1:0] DEPTH_WORDS = XLEN'(IMEM_DEPTH);

   logic [31:0]     mem [IMEM_DEPTH];
   logic [XLEN-1:0] pc_f;
   logic            inflight;
   logic [XLEN-1:0] inflight_pc;
   logic [31:0]     rdata_q;

   fetch_entry_t    enq_entry;
   fetch_entry_t    buf_head;
   fetch_entry_t    head;
   logic [1:0]      buf_count;
   logic            buf_full;
   logic            buf_empty;
   logic            buf_enq;
   logic            buf_deq;

   logic            land_halt;
   logic            land_ok;
   logic            fire;
   logic [2:0]      occupancy;
   logic            pc_bad;
   logic            try_issue;
   logic            issue;
   logic            set_fault;

   assign enq_entry = '{instr: rdata_q, pc: inflight_pc};
   assign land_halt = inflight && (rdata_q == HALT_WORD);
   assign land_ok   = inflight && !land_halt;
   assign pc_bad    = (pc_f[1:0] != 2'b00) || ((pc_f >> 2) >= DEPTH_WORDS);

   always_comb begin
      // NOTE: every variable of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      head      = buf_head;
      if_valid  = 1'b0;
      if_instr  = '0;
      if_pc     = '0;
      fire      = 1'b0;
      buf_deq   = 1'b0;
      buf_enq   = 1'b0;
      occupancy = '0;
      try_issue = 1'b0;
      issue     = 1'b0;
      set_fault = 1'b0;

      // Bypass: with the buffer empty, the returning word is the head.
      if (buf_empty) head = enq_entry;
      if_valid = !buf_empty || land_ok;
      if (if_valid) begin
         if_instr = head.instr;
         if_pc    = head.pc;
      end

      fire    = if_valid && if_ready;
      buf_deq = fire && !buf_empty;
      // The returning word is buffered unless it was consumed via the bypass
      // or the redirect is discarding it.
      buf_enq = land_ok && !redirect_valid && !(fire && buf_empty) && !buf_full;

      // Entries still held after this edge, before any new read.
      occupancy = 3'(buf_count) + 3'(land_ok) - 3'(fire);

      // A halt word landing now also blocks the read that would follow it.
      try_issue = run && !halted && !fault && !redirect_valid && !land_halt
                  && (occupancy < 3'd2);
      issue     = try_issue && !pc_bad;
      set_fault = try_issue && pc_bad;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_f        <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else if (redirect_valid) begin
         pc_f     <= redirect_pc;
         inflight <= 1'b0;
         halted   <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc_f        <= pc_f + XLEN'(4);
            inflight_pc <= pc_f;
         end
         if (land_halt) halted <= 1'b1;
         if (set_fault) fault  <= 1'b1;
      end
   end

   // Read-first: a write to the word being read this edge returns the old word.
   always_ff @(posedge clk) begin
      if (imem_we) mem[imem_waddr] <= imem_wdata;
      if (issue)   rdata_q <= mem[pc_f[2 +: AW]];
   end

   fetch_buffer u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .enq      (buf_enq),
      .enq_data (enq_entry),
      .deq      (buf_deq),
      .head     (buf_head),
      .count    (buf_count),
      .full     (buf_full),
      .empty    (buf_empty)
   );

endmodule
